// File: rtl/cpu_axi_pkg.sv
// Shared definitions for the CPU AXI3 master arbiter.
// Holds bus widths, default IDs, the cache-line offset width, the one-hot
// read/write FSM encodings and the latched address-channel payload struct.
package cpu_axi_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ID_W-1:0] ID_IC_DEF      = 4'd0;
    localparam logic [ID_W-1:0] ID_DC_DEF      = 4'd1;
    localparam int unsigned     LINE_OFF_W_DEF = 5;

    // One-hot, matching the style of the dcache status bus
    typedef enum logic [2:0] {
        R_IDLE = 3'b001,
        R_AR   = 3'b010,
        R_DATA = 3'b100
    } r_state_t;

    typedef enum logic [3:0] {
        W_IDLE = 4'b0001,
        W_AW   = 4'b0010,
        W_DATA = 4'b0100,
        W_RESP = 4'b1000
    } w_state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    // Latched AR/AW payload
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        logic [SIZE_W-1:0] size;
    } ax_req_t;

endpackage

// File: rtl/cpu_axi_arbiter_wlast.sv
// axi_wlast_gen: counts accepted W beats of the current write burst and flags
// the beat whose index equals the latched AWLEN.
// Ports: aclk/aresetn clock and sync active-low reset; clear restarts the
// count at 0; advance steps it on a W handshake; len is the latched AWLEN;
// last is high while the current beat index equals len.
module axi_wlast_gen
    import cpu_axi_pkg::*;
(
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             advance,
    input  logic [LEN_W-1:0] len,
    output logic             last
);

    logic [LEN_W-1:0] beat_cnt;

    // Beat counter; clear wins because it marks the start of a new burst
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            beat_cnt <= '0;
        end else if (clear) begin
            beat_cnt <= '0;
        end else if (advance) begin
            beat_cnt <= beat_cnt + LEN_W'(1);
        end
    end

    assign last = (beat_cnt == len);

endmodule

// File: rtl/cpu_axi_arbiter.sv
// cpu_axi_arbiter: merges the icache read port and the dcache read/write port
// onto the core's single AXI3 master.
// Ports: ic_* icache AR request and routed R beats; dc_* dcache AR/AW/W
// requests, routed R beats and write-response pulse; ar*/r*/aw*/w*/b* the AXI3
// master channels. Reads run one burst at a time with round-robin on conflict;
// writes run concurrently, except that a dcache read to the line of a pending
// write is held until the write has completed.
module cpu_axi_arbiter
    import cpu_axi_pkg::*;
#(
    parameter logic [ID_W-1:0] ID_IC      = ID_IC_DEF,
    parameter logic [ID_W-1:0] ID_DC      = ID_DC_DEF,
    parameter int unsigned     LINE_OFF_W = LINE_OFF_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    // icache read port
    input  logic [ADDR_W-1:0] ic_araddr,
    input  logic [LEN_W-1:0]  ic_arlen,
    input  logic [SIZE_W-1:0] ic_arsize,
    input  logic              ic_arvalid,
    output logic              ic_arready,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_rvalid,
    output logic              ic_rlast,
    // dcache read port
    input  logic [ADDR_W-1:0] dc_araddr,
    input  logic [LEN_W-1:0]  dc_arlen,
    input  logic [SIZE_W-1:0] dc_arsize,
    input  logic              dc_arvalid,
    output logic              dc_arready,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_rvalid,
    output logic              dc_rlast,
    // dcache write port
    input  logic [ADDR_W-1:0] dc_awaddr,
    input  logic [LEN_W-1:0]  dc_awlen,
    input  logic [SIZE_W-1:0] dc_awsize,
    input  logic              dc_awvalid,
    output logic              dc_awready,
    input  logic [DATA_W-1:0] dc_wdata,
    input  logic [STRB_W-1:0] dc_wstrb,
    input  logic              dc_wvalid,
    output logic              dc_wready,
    output logic              dc_bvalid,
    // AXI AR
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic [SIZE_W-1:0] arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // AXI R
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,
    // AXI AW
    output logic [ID_W-1:0]   awid,
    output logic [ADDR_W-1:0] awaddr,
    output logic [LEN_W-1:0]  awlen,
    output logic [SIZE_W-1:0] awsize,
    output logic [1:0]        awburst,
    output logic [1:0]        awlock,
    output logic [3:0]        awcache,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,
    // AXI W
    output logic [ID_W-1:0]   wid,
    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    // AXI B
    input  logic [ID_W-1:0]   bid,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W;

    r_state_t r_state, r_next;
    w_state_t w_state, w_next;
    owner_t   owner_q, last_owner_q;
    ax_req_t  ar_q, aw_q;
    logic     err_q;

    logic            grant_ic, grant_dc, beat_ok, beat_bad;
    logic            aw_accept, w_hs, b_done, last_beat;
    logic            ic_elig, dc_elig, raw_block;
    logic [ID_W-1:0] owner_id;
    logic            route_ic, route_dc;
    logic            in_wdata;
    logic            unused_ok;

    assign owner_id = (owner_q == OWN_IC) ? ID_IC : ID_DC;

    // Same-line RAW hazard: pending write, or a write being accepted this cycle
    always_comb begin
        raw_block = 1'b0;
        if (w_state != W_IDLE) begin
            raw_block = (dc_araddr[ADDR_W-1:LINE_OFF_W] == aw_q.addr[ADDR_W-1:LINE_OFF_W]);
        end else if (dc_awvalid) begin
            raw_block = (dc_araddr[ADDR_W-1:LINE_OFF_W] == dc_awaddr[ADDR_W-1:LINE_OFF_W]);
        end
    end

    assign ic_elig = ic_arvalid;
    assign dc_elig = dc_arvalid && !raw_block;

    // Read FSM next state and per-cycle decisions
    always_comb begin
        r_next   = r_state;
        grant_ic = 1'b0;
        grant_dc = 1'b0;
        beat_ok  = 1'b0;
        beat_bad = 1'b0;
        case (r_state)
            R_IDLE: begin
                grant_ic = ic_elig && (!dc_elig || (last_owner_q == OWN_DC));
                grant_dc = dc_elig && !grant_ic;
                if (grant_ic || grant_dc) begin
                    r_next = R_AR;
                end
            end
            R_AR: begin
                if (arready) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid) begin
                    // Beats carrying a foreign ID are dropped and do not end the burst
                    if (rid == owner_id) begin
                        beat_ok = 1'b1;
                        if (rlast) begin
                            r_next = R_IDLE;
                        end
                    end else begin
                        beat_bad = 1'b1;
                    end
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM state, request latches and round-robin history
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= R_IDLE;
            owner_q      <= OWN_IC;
            last_owner_q <= OWN_DC;
            ar_q         <= '0;
            err_q        <= 1'b0;
        end else begin
            r_state <= r_next;
            if (grant_ic) begin
                owner_q      <= OWN_IC;
                last_owner_q <= OWN_IC;
                ar_q         <= '{addr: ic_araddr, len: ic_arlen, size: ic_arsize};
            end else if (grant_dc) begin
                owner_q      <= OWN_DC;
                last_owner_q <= OWN_DC;
                ar_q         <= '{addr: dc_araddr, len: dc_arlen, size: dc_arsize};
            end
            if (beat_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // Write FSM next state and per-cycle decisions
    always_comb begin
        w_next    = w_state;
        aw_accept = 1'b0;
        w_hs      = 1'b0;
        b_done    = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (dc_awvalid) begin
                    aw_accept = 1'b1;
                    w_next    = W_AW;
                end
            end
            W_AW: begin
                if (awready) begin
                    w_next = W_DATA;
                end
            end
            W_DATA: begin
                w_hs = dc_wvalid && wready;
                if (w_hs && last_beat) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid) begin
                    b_done = 1'b1;
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM state and AW latch
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            aw_q    <= '0;
        end else begin
            w_state <= w_next;
            if (aw_accept) begin
                aw_q <= '{addr: dc_awaddr, len: dc_awlen, size: dc_awsize};
            end
        end
    end

    axi_wlast_gen u_wlast (
        .aclk    (aclk),
        .aresetn (aresetn),
        .clear   (aw_accept),
        .advance (w_hs),
        .len     (aw_q.len),
        .last    (last_beat)
    );

    // Handshake outputs are forced low while reset is asserted
    assign route_ic = aresetn && beat_ok && (owner_q == OWN_IC);
    assign route_dc = aresetn && beat_ok && (owner_q == OWN_DC);
    assign in_wdata = aresetn && (w_state == W_DATA);

    assign ic_arready = aresetn && grant_ic;
    assign dc_arready = aresetn && grant_dc;
    assign ic_rvalid  = route_ic;
    assign ic_rlast   = route_ic && rlast;
    assign ic_rdata   = route_ic ? rdata : '0;
    assign dc_rvalid  = route_dc;
    assign dc_rlast   = route_dc && rlast;
    assign dc_rdata   = route_dc ? rdata : '0;

    assign arid    = owner_id;
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = aresetn && (r_state == R_AR);
    assign rready  = 1'b1;

    assign dc_awready = aresetn && (w_state == W_IDLE);
    assign awid    = ID_DC;
    assign awaddr  = aw_q.addr;
    assign awlen   = aw_q.len;
    assign awsize  = aw_q.size;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = aresetn && (w_state == W_AW);

    assign wid       = ID_DC;
    assign wvalid    = in_wdata && dc_wvalid;
    assign dc_wready = in_wdata && wready;
    assign wdata     = in_wdata ? dc_wdata : '0;
    assign wstrb     = in_wdata ? dc_wstrb : '0;
    assign wlast     = in_wdata && last_beat;

    assign bready    = 1'b1;
    assign dc_bvalid = aresetn && b_done;

    // Response codes are not propagated; err_q is observed by debug only
    assign unused_ok = ^{rresp, bid, bresp, err_q};

endmodule

// File: tb/tb_cpu_axi_arbiter.sv
module tb_cpu_axi_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] ic_araddr, dc_araddr, dc_awaddr;
    logic [3:0]  ic_arlen, dc_arlen, dc_awlen;
    logic [2:0]  ic_arsize, dc_arsize, dc_awsize;
    logic        ic_arvalid, ic_arready, ic_rvalid, ic_rlast;
    logic [31:0] ic_rdata, dc_rdata;
    logic        dc_arvalid, dc_arready, dc_rvalid, dc_rlast;
    logic        dc_awvalid, dc_awready;
    logic [31:0] dc_wdata;
    logic [3:0]  dc_wstrb;
    logic        dc_wvalid, dc_wready, dc_bvalid;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, rid, bid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    int checks = 0;
    int errors = 0;

    always #5 aclk = ~aclk;

    cpu_axi_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .ic_araddr(ic_araddr), .ic_arlen(ic_arlen), .ic_arsize(ic_arsize),
        .ic_arvalid(ic_arvalid), .ic_arready(ic_arready),
        .ic_rdata(ic_rdata), .ic_rvalid(ic_rvalid), .ic_rlast(ic_rlast),
        .dc_araddr(dc_araddr), .dc_arlen(dc_arlen), .dc_arsize(dc_arsize),
        .dc_arvalid(dc_arvalid), .dc_arready(dc_arready),
        .dc_rdata(dc_rdata), .dc_rvalid(dc_rvalid), .dc_rlast(dc_rlast),
        .dc_awaddr(dc_awaddr), .dc_awlen(dc_awlen), .dc_awsize(dc_awsize),
        .dc_awvalid(dc_awvalid), .dc_awready(dc_awready),
        .dc_wdata(dc_wdata), .dc_wstrb(dc_wstrb), .dc_wvalid(dc_wvalid),
        .dc_wready(dc_wready), .dc_bvalid(dc_bvalid),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ic_araddr = '0; ic_arlen = '0; ic_arsize = 3'd2; ic_arvalid = 1'b0;
        dc_araddr = '0; dc_arlen = '0; dc_arsize = 3'd2; dc_arvalid = 1'b0;
        dc_awaddr = '0; dc_awlen = '0; dc_awsize = 3'd2; dc_awvalid = 1'b0;
        dc_wdata = '0; dc_wstrb = '0; dc_wvalid = 1'b0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ic_n;
        int hs;
        int nlast;

        // ---------------- reset state ----------------
        aresetn = 1'b0;
        clear_inputs();
        step();
        step();
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_awvalid", 32'(awvalid), 0);
        chk("rst_wvalid", 32'(wvalid), 0);
        chk("rst_dc_awready", 32'(dc_awready), 0);
        chk("rst_ic_arready", 32'(ic_arready), 0);
        chk("rst_rready", 32'(rready), 1);
        chk("rst_bready", 32'(bready), 1);
        chk("rst_araddr", araddr, 0);
        chk("rst_awaddr", awaddr, 0);
        chk("rst_wlast", 32'(wlast), 0);
        chk("rst_dc_bvalid", 32'(dc_bvalid), 0);
        chk("rst_err", 32'(dut.err_q), 0);
        aresetn = 1'b1;
        #1;
        chk("idle_dc_awready", 32'(dc_awready), 1);

        // ---------------- icache 8-beat read ----------------
        ic_araddr = 32'hBFC0_0000; ic_arlen = 4'd7; ic_arvalid = 1'b1;
        #1;
        chk("ic_arready", 32'(ic_arready), 1);
        chk("ic_only_dc_arready", 32'(dc_arready), 0);
        step();
        ic_arvalid = 1'b0;
        #1;
        chk("ic_arvalid", 32'(arvalid), 1);
        chk("ic_araddr", araddr, 32'hBFC0_0000);
        chk("ic_arlen", 32'(arlen), 7);
        chk("ic_arsize", 32'(arsize), 2);
        chk("ic_arid", 32'(arid), 0);
        chk("ic_arburst", 32'(arburst), 1);
        arready = 1'b1;
        step();
        arready = 1'b0;
        ic_n = 0;
        for (int i = 0; i < 8; i++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'(i); rlast = (i == 7);
            #1;
            if (ic_rvalid) ic_n++;
            chk("ic_rdata", ic_rdata, 32'(i));
            chk("ic_rlast", 32'(ic_rlast), (i == 7) ? 1 : 0);
            chk("ic_burst_dc_rvalid", 32'(dc_rvalid), 0);
            step();
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("ic_beats", 32'(ic_n), 8);
        chk("ic_done_arvalid", 32'(arvalid), 0);

        // ---------------- IC/DC conflict after reset ----------------
        do_reset();
        ic_araddr = 32'h0000_1000; ic_arlen = 4'd0; ic_arvalid = 1'b1;
        dc_araddr = 32'h0000_2000; dc_arlen = 4'd0; dc_arvalid = 1'b1;
        #1;
        chk("rr_ic_arready", 32'(ic_arready), 1);
        chk("rr_dc_arready", 32'(dc_arready), 0);
        step();
        ic_arvalid = 1'b0;
        #1;
        chk("rr_first_arid", 32'(arid), 0);
        chk("rr_first_araddr", araddr, 32'h0000_1000);
        chk("rr_busy_dc_arready", 32'(dc_arready), 0);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'hAAAA; rlast = 1'b1;
        #1;
        chk("rr_ic_rvalid", 32'(ic_rvalid), 1);
        chk("rr_ic_beat_dc_rvalid", 32'(dc_rvalid), 0);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        chk("rr_dc_grant", 32'(dc_arready), 1);
        step();
        dc_arvalid = 1'b0;
        #1;
        chk("rr_second_arvalid", 32'(arvalid), 1);
        chk("rr_second_arid", 32'(arid), 1);
        chk("rr_second_araddr", araddr, 32'h0000_2000);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hBBBB; rlast = 1'b1;
        #1;
        chk("rr_dc_rvalid", 32'(dc_rvalid), 1);
        chk("rr_dc_rdata", dc_rdata, 32'hBBBB);
        chk("rr_dc_rlast", 32'(dc_rlast), 1);
        chk("rr_dc_beat_ic_rvalid", 32'(ic_rvalid), 0);
        step();
        rvalid = 1'b0; rlast = 1'b0;

        // ---------------- dcache 8-beat write, wready toggling ----------------
        dc_awaddr = 32'h8000_1000; dc_awlen = 4'd7; dc_awvalid = 1'b1;
        #1;
        chk("wr_dc_awready", 32'(dc_awready), 1);
        step();
        dc_awvalid = 1'b0;
        #1;
        chk("wr_awvalid", 32'(awvalid), 1);
        chk("wr_awaddr", awaddr, 32'h8000_1000);
        chk("wr_awlen", 32'(awlen), 7);
        chk("wr_awid", 32'(awid), 1);
        chk("wr_awburst", 32'(awburst), 1);
        awready = 1'b1;
        step();
        awready = 1'b0;
        hs = 0;
        nlast = 0;
        for (int c = 0; c < 40 && hs < 8; c++) begin
            dc_wvalid = 1'b1; dc_wdata = 32'h100 + 32'(hs); dc_wstrb = 4'hF;
            wready = c[0];
            #1;
            chk("wr_wvalid", 32'(wvalid), 1);
            chk("wr_wdata", wdata, 32'h100 + 32'(hs));
            chk("wr_dc_wready", 32'(dc_wready), 32'(wready));
            if (wready) begin
                chk("wr_wlast", 32'(wlast), (hs == 7) ? 1 : 0);
                if (wlast) nlast++;
                hs++;
            end
            step();
        end
        wready = 1'b1;
        #1;
        chk("wr_after8_wvalid", 32'(wvalid), 0);
        chk("wr_wlast_count", 32'(nlast), 1);
        dc_wvalid = 1'b0; wready = 1'b0;
        #1;
        chk("wr_no_b_dc_bvalid", 32'(dc_bvalid), 0);
        bvalid = 1'b1;
        #1;
        chk("wr_dc_bvalid", 32'(dc_bvalid), 1);
        step();
        chk("wr_bpulse_end", 32'(dc_bvalid), 0);
        chk("wr_back_idle", 32'(dc_awready), 1);
        bvalid = 1'b0;

        // ---------------- same-line RAW block ----------------
        dc_awaddr = 32'h8000_1000; dc_awlen = 4'd0; dc_awvalid = 1'b1;
        dc_araddr = 32'h8000_1010; dc_arlen = 4'd0; dc_arvalid = 1'b1;
        #1;
        chk("raw_same_cycle_awready", 32'(dc_awready), 1);
        chk("raw_same_cycle_arready", 32'(dc_arready), 0);
        step();
        dc_awvalid = 1'b0;
        #1;
        chk("raw_aw_arready", 32'(dc_arready), 0);
        chk("raw_aw_arvalid", 32'(arvalid), 0);
        awready = 1'b1;
        step();
        awready = 1'b0;
        dc_wvalid = 1'b1; wready = 1'b1; dc_wdata = 32'h55; dc_wstrb = 4'h3;
        #1;
        chk("raw_single_wlast", 32'(wlast), 1);
        chk("raw_wstrb", 32'(wstrb), 32'h3);
        chk("raw_data_arready", 32'(dc_arready), 0);
        step();
        dc_wvalid = 1'b0; wready = 1'b0;
        #1;
        chk("raw_resp_arready", 32'(dc_arready), 0);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        #1;
        chk("raw_released_arready", 32'(dc_arready), 1);
        step();
        dc_arvalid = 1'b0;
        #1;
        chk("raw_arvalid", 32'(arvalid), 1);
        chk("raw_araddr", araddr, 32'h8000_1010);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rdata = 32'hCC; rlast = 1'b1;
        #1;
        chk("raw_dc_rvalid", 32'(dc_rvalid), 1);
        step();
        rvalid = 1'b0; rlast = 1'b0;

        // ---------------- different-line read runs concurrently ----------------
        dc_awaddr = 32'h8000_1000; dc_awlen = 4'd0; dc_awvalid = 1'b1;
        step();
        dc_awvalid = 1'b0;
        dc_araddr = 32'h8000_2000; dc_arvalid = 1'b1;
        #1;
        chk("conc_dc_arready", 32'(dc_arready), 1);
        step();
        dc_arvalid = 1'b0;
        #1;
        chk("conc_arvalid", 32'(arvalid), 1);
        chk("conc_awvalid", 32'(awvalid), 1);
        chk("conc_araddr", araddr, 32'h8000_2000);
        arready = 1'b1; awready = 1'b1;
        step();
        arready = 1'b0; awready = 1'b0;
        rvalid = 1'b1; rid = 4'd1; rlast = 1'b1; dc_wvalid = 1'b1; wready = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0; dc_wvalid = 1'b0; wready = 1'b0;
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;

        // ---------------- reset during beat 4 of an 8-beat read ----------------
        ic_araddr = 32'h0000_3000; ic_arlen = 4'd7; ic_arvalid = 1'b1;
        step();
        ic_arvalid = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rid = 4'd0; rdata = 32'(i); rlast = 1'b0;
            step();
        end
        rdata = 32'd3;
        aresetn = 1'b0;
        #1;
        chk("mid_rst_ic_rvalid", 32'(ic_rvalid), 0);
        step();
        aresetn = 1'b1;
        rdata = 32'd4;
        #1;
        chk("post_rst_arvalid", 32'(arvalid), 0);
        chk("post_rst_ic_rvalid", 32'(ic_rvalid), 0);
        rvalid = 1'b0;
        ic_araddr = 32'h0000_4000; ic_arlen = 4'd0; ic_arvalid = 1'b1;
        #1;
        chk("post_rst_ic_arready", 32'(ic_arready), 1);
        step();
        ic_arvalid = 1'b0;
        #1;
        chk("post_rst_new_arvalid", 32'(arvalid), 1);
        chk("post_rst_new_araddr", araddr, 32'h0000_4000);
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rlast = 1'b1;
        step();
        rvalid = 1'b0; rlast = 1'b0;

        // ---------------- foreign rid during an icache burst ----------------
        chk("err_before", 32'(dut.err_q), 0);
        ic_araddr = 32'h0000_5000; ic_arlen = 4'd2; ic_arvalid = 1'b1;
        step();
        ic_arvalid = 1'b0;
        arready = 1'b1;
        step();
        arready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h10; rlast = 1'b0;
        #1;
        chk("bad_beat0_rvalid", 32'(ic_rvalid), 1);
        step();
        rid = 4'd3; rdata = 32'hDEAD; rlast = 1'b1;
        #1;
        chk("bad_ic_rvalid", 32'(ic_rvalid), 0);
        chk("bad_dc_rvalid", 32'(dc_rvalid), 0);
        step();
        chk("bad_err_set", 32'(dut.err_q), 1);
        rid = 4'd0; rdata = 32'h11; rlast = 1'b0;
        #1;
        chk("bad_beat1_rvalid", 32'(ic_rvalid), 1);
        chk("bad_beat1_rdata", ic_rdata, 32'h11);
        step();
        rdata = 32'h12; rlast = 1'b1;
        #1;
        chk("bad_beat2_rlast", 32'(ic_rlast), 1);
        step();
        rvalid = 1'b0; rlast = 1'b0;
        ic_araddr = 32'h0000_6000; ic_arlen = 4'd0; ic_arvalid = 1'b1;
        #1;
        chk("bad_done_ic_arready", 32'(ic_arready), 1);
        chk("bad_err_sticky", 32'(dut.err_q), 1);
        step();
        ic_arvalid = 1'b0;
        #1;
        chk("bad_done_arvalid", 32'(arvalid), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
